// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings, arbiter FSM states and the latched request record
// used by the two-port AHB master arbiter.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_ERR,
    ST_LERR
  } ahb_state_e;

  typedef enum logic {
    PORT_D = 1'b0,
    PORT_F = 1'b1
  } ahb_port_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  size;
    logic        write;
    ahb_port_e   port;
  } ahb_req_t;

  // Sizes above a word are not supported by this 32-bit bus, so they count as misaligned.
  function automatic logic is_misaligned(input logic [2:0] size, input logic [1:0] addr_lo);
    logic bad;
    case (size)
      HSIZE_BYTE: bad = 1'b0;
      HSIZE_HALF: bad = addr_lo[0];
      HSIZE_WORD: bad = (addr_lo != 2'b00);
      default:    bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/ahb_port_arbiter_if.sv
// Requester ports (data and fetch) plus the AHB-Lite master bus of the arbiter.
interface ahb_port_arbiter_if;

  logic        d_req;
  logic        d_write;
  logic [31:0] d_addr;
  logic [2:0]  d_size;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_done;
  logic        d_err;
  logic [31:0] d_rdata;

  logic        f_req;
  logic [31:0] f_addr;
  logic        f_gnt;
  logic        f_done;
  logic        f_err;
  logic [31:0] f_rdata;

  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;

  modport master (
    input  d_req, d_write, d_addr, d_size, d_wdata,
    output d_gnt, d_done, d_err, d_rdata,
    input  f_req, f_addr,
    output f_gnt, f_done, f_err, f_rdata,
    output HADDR, HTRANS, HWRITE, HSIZE, HWDATA,
    input  HRDATA, HREADY, HRESP
  );

  modport slave (
    output d_req, d_write, d_addr, d_size, d_wdata,
    input  d_gnt, d_done, d_err, d_rdata,
    output f_req, f_addr,
    input  f_gnt, f_done, f_err, f_rdata,
    input  HADDR, HTRANS, HWRITE, HSIZE, HWDATA,
    output HRDATA, HREADY, HRESP
  );

endinterface

// File: rtl/ahb_prio_starve_arb.sv
// Fixed-priority data-over-fetch arbitration with a saturating starvation counter
// that lets a waiting fetch win once it has lost STARVE_MAX times in a row.
module ahb_prio_starve_arb #(
  parameter int STARVE_MAX = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       arb_en,
  input  logic       d_req,
  input  logic       f_req,
  output logic [1:0] grant
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [3:0] starve_cnt;
  logic       fetch_urgent;

  assign fetch_urgent = f_req && (starve_cnt >= STARVE_LIM);

  // grant[0] = data port, grant[1] = fetch port; only meaningful while the FSM is idle.
  always_comb begin
    grant = 2'b00;
    if (arb_en) begin
      if (d_req && !fetch_urgent) begin
        grant = 2'b01;
      end else if (f_req) begin
        grant = 2'b10;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= 4'd0;
    end else if (arb_en) begin
      if (grant[1] || !f_req) begin
        starve_cnt <= 4'd0;
      end else if (grant[0] && (starve_cnt != 4'd15)) begin
        starve_cnt <= starve_cnt + 4'd1;
      end
    end
  end

endmodule

// File: rtl/ahb_port_arbiter.sv
// Shares one non-pipelined AHB-Lite master port between the data and fetch requesters;
// misaligned data accesses are answered locally with an error and never reach the bus.
module ahb_port_arbiter
  import ahb_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input logic              clk,
  input logic              rst,
  ahb_port_arbiter_if.master bus
);

  ahb_state_e  state, state_next;
  ahb_req_t    new_req;
  ahb_port_e   port_q;
  logic        write_q;
  logic [1:0]  grant;
  logic        gnt_d, gnt_f, done, err;

  logic [31:0] haddr_q, hwdata_q, d_rdata_q, f_rdata_q;
  logic [1:0]  htrans_q;
  logic        hwrite_q;
  logic [2:0]  hsize_q;

  ahb_prio_starve_arb #(.STARVE_MAX(STARVE_MAX)) u_arb (
    .clk    (clk),
    .rst    (rst),
    .arb_en (state == ST_IDLE),
    .d_req  (bus.d_req),
    .f_req  (bus.f_req),
    .grant  (grant)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    new_req    = '0;
    gnt_d      = 1'b0;
    gnt_f      = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    case (state)
      ST_IDLE: begin
        if (grant[0]) begin
          gnt_d         = 1'b1;
          new_req.addr  = bus.d_addr;
          new_req.wdata = bus.d_wdata;
          new_req.size  = bus.d_size;
          new_req.write = bus.d_write;
          new_req.port  = PORT_D;
          state_next    = is_misaligned(bus.d_size, bus.d_addr[1:0]) ? ST_LERR : ST_ADDR;
        end else if (grant[1]) begin
          gnt_f         = 1'b1;
          new_req.addr  = bus.f_addr & 32'hFFFF_FFFC;
          new_req.size  = HSIZE_WORD;
          new_req.port  = PORT_F;
          state_next    = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (bus.HREADY) state_next = ST_DATA;
      end
      ST_DATA: begin
        // A one-cycle ERROR (HREADY and HRESP both high) is still reported as an error.
        if (bus.HREADY) begin
          done       = 1'b1;
          err        = bus.HRESP;
          state_next = ST_IDLE;
        end else if (bus.HRESP) begin
          state_next = ST_ERR;
        end
      end
      ST_ERR: begin
        if (bus.HREADY) begin
          done       = 1'b1;
          err        = 1'b1;
          state_next = ST_IDLE;
        end
      end
      ST_LERR: begin
        done       = 1'b1;
        err        = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Bus registers load only for transfers that really go on the bus.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      port_q    <= PORT_D;
      write_q   <= 1'b0;
      haddr_q   <= 32'h0;
      htrans_q  <= HTRANS_IDLE;
      hwrite_q  <= 1'b0;
      hsize_q   <= HSIZE_WORD;
      hwdata_q  <= 32'h0;
      d_rdata_q <= 32'h0;
      f_rdata_q <= 32'h0;
    end else begin
      htrans_q <= (state_next == ST_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
      if (gnt_d || gnt_f) begin
        port_q  <= new_req.port;
        write_q <= new_req.write;
        if (state_next == ST_ADDR) begin
          haddr_q  <= new_req.addr;
          hwrite_q <= new_req.write;
          hsize_q  <= new_req.size;
          hwdata_q <= new_req.wdata;
        end
      end
      if (done && !err && !write_q) begin
        if (port_q == PORT_D) d_rdata_q <= bus.HRDATA;
        else                  f_rdata_q <= bus.HRDATA;
      end
    end
  end

  assign bus.d_gnt   = gnt_d;
  assign bus.f_gnt   = gnt_f;
  assign bus.d_done  = done && (port_q == PORT_D);
  assign bus.f_done  = done && (port_q == PORT_F);
  assign bus.d_err   = err && (port_q == PORT_D);
  assign bus.f_err   = err && (port_q == PORT_F);
  assign bus.d_rdata = d_rdata_q;
  assign bus.f_rdata = f_rdata_q;
  assign bus.HADDR   = haddr_q;
  assign bus.HTRANS  = htrans_q;
  assign bus.HWRITE  = hwrite_q;
  assign bus.HSIZE   = hsize_q;
  assign bus.HWDATA  = hwdata_q;

endmodule

// File: tb/tb_ahb_port_arbiter.sv
// Self-checking bench for ahb_port_arbiter: scenario tasks drive the requesters and a
// hand-driven slave; a scoreboard monitor checks every done pulse and the rdata after it.
module tb_ahb_port_arbiter;
  import ahb_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  typedef struct {
    ahb_port_e   port;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] model_d_rdata = 32'h0;
  logic [31:0] model_f_rdata = 32'h0;

  ahb_port_arbiter_if bus ();

  ahb_port_arbiter #(.STARVE_MAX(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input ahb_port_e port, input logic err, input logic is_read,
                          input logic [31:0] data);
    exp_t e;
    if (is_read && !err) begin
      if (port == PORT_D) model_d_rdata = data;
      else                model_f_rdata = data;
    end
    e.port  = port;
    e.err   = err;
    e.rdata = (port == PORT_D) ? model_d_rdata : model_f_rdata;
    sb_q.push_back(e);
  endtask

  // Scoreboard monitor: done pulses pop an expectation; rdata is checked one cycle later.
  exp_t        mon_e;
  ahb_port_e   mon_port;
  logic        mon_err;
  logic        chk_pending = 1'b0;
  ahb_port_e   chk_port = PORT_D;
  logic [31:0] chk_val = 32'h0;
  logic [31:0] mon_got;

  always @(negedge clk) begin
    if (rst) begin
      chk_pending = 1'b0;
    end else begin
      if (chk_pending) begin
        mon_got = (chk_port == PORT_D) ? bus.d_rdata : bus.f_rdata;
        total++;
        if (mon_got !== chk_val) begin
          bad++;
          $display("[TB] FAIL sb_rdata port=%0d got=%h exp=%h", chk_port, mon_got, chk_val);
        end
        chk_pending = 1'b0;
      end
      if (bus.d_done || bus.f_done) begin
        total++;
        if (bus.d_done && bus.f_done) begin
          bad++;
          $display("[TB] FAIL done_exclusive got d_done=1 f_done=1 exp one only");
        end else if (sb_q.size() == 0) begin
          bad++;
          $display("[TB] FAIL sb_unexpected_done got d_done=%b f_done=%b exp none",
                   bus.d_done, bus.f_done);
        end else begin
          mon_e    = sb_q.pop_front();
          mon_port = bus.f_done ? PORT_F : PORT_D;
          mon_err  = bus.f_done ? bus.f_err : bus.d_err;
          if (mon_port !== mon_e.port || mon_err !== mon_e.err) begin
            bad++;
            $display("[TB] FAIL sb_done got port=%0d err=%b exp port=%0d err=%b",
                     mon_port, mon_err, mon_e.port, mon_e.err);
          end
          chk_pending = 1'b1;
          chk_port    = mon_e.port;
          chk_val     = mon_e.rdata;
        end
      end
    end
  end

  task automatic test_reset;
    @(negedge clk);
    total++;
    if (bus.HTRANS !== HTRANS_IDLE || bus.HADDR !== 32'h0 || bus.HWRITE !== 1'b0 ||
        bus.HSIZE !== HSIZE_WORD || bus.HWDATA !== 32'h0) begin
      bad++;
      $display("[TB] FAIL reset_bus got htrans=%b haddr=%h hwrite=%b hsize=%b hwdata=%h exp 00/0/0/010/0",
               bus.HTRANS, bus.HADDR, bus.HWRITE, bus.HSIZE, bus.HWDATA);
    end
    total++;
    if ({bus.d_gnt, bus.d_done, bus.d_err, bus.f_gnt, bus.f_done, bus.f_err} !== 6'b0) begin
      bad++;
      $display("[TB] FAIL reset_handshake got %b exp 000000",
               {bus.d_gnt, bus.d_done, bus.d_err, bus.f_gnt, bus.f_done, bus.f_err});
    end
    total++;
    if (bus.d_rdata !== 32'h0 || bus.f_rdata !== 32'h0) begin
      bad++;
      $display("[TB] FAIL reset_rdata got d=%h f=%h exp 0/0", bus.d_rdata, bus.f_rdata);
    end
    next_cycle;
    rst = 1'b0;
  endtask

  task automatic test_zero_wait_load;
    next_cycle;
    bus.d_req = 1'b1; bus.d_write = 1'b0; bus.d_addr = 32'h100; bus.d_size = HSIZE_WORD;
    push_exp(PORT_D, 1'b0, 1'b1, 32'hDEADBEEF);
    @(negedge clk);
    total++;
    if (bus.d_gnt !== 1'b1 || bus.f_gnt !== 1'b0) begin
      bad++;
      $display("[TB] FAIL load_gnt got d_gnt=%b f_gnt=%b exp 1/0", bus.d_gnt, bus.f_gnt);
    end
    next_cycle;
    bus.d_req = 1'b0;
    @(negedge clk);
    total++;
    if (bus.HTRANS !== HTRANS_NONSEQ || bus.HADDR !== 32'h100 || bus.HWRITE !== 1'b0) begin
      bad++;
      $display("[TB] FAIL load_addr got htrans=%b haddr=%h hwrite=%b exp 10/100/0",
               bus.HTRANS, bus.HADDR, bus.HWRITE);
    end
    next_cycle;
    bus.HRDATA = 32'hDEADBEEF;
    @(negedge clk);
    total++;
    if (bus.d_done !== 1'b1 || bus.d_err !== 1'b0 || bus.HTRANS !== HTRANS_IDLE) begin
      bad++;
      $display("[TB] FAIL load_done got d_done=%b d_err=%b htrans=%b exp 1/0/00",
               bus.d_done, bus.d_err, bus.HTRANS);
    end
    next_cycle;
    bus.HRDATA = 32'h0;
    @(negedge clk);
    total++;
    if (bus.d_rdata !== 32'hDEADBEEF) begin
      bad++;
      $display("[TB] FAIL load_rdata got %h exp deadbeef", bus.d_rdata);
    end
  endtask

  task automatic test_store_wait;
    next_cycle;
    bus.d_req = 1'b1; bus.d_write = 1'b1; bus.d_addr = 32'h200;
    bus.d_size = HSIZE_WORD; bus.d_wdata = 32'h12345678;
    push_exp(PORT_D, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    total++;
    if (bus.d_gnt !== 1'b1) begin
      bad++;
      $display("[TB] FAIL store_gnt got %b exp 1", bus.d_gnt);
    end
    next_cycle;
    bus.d_req = 1'b0; bus.d_write = 1'b0;
    @(negedge clk);
    total++;
    if (bus.HTRANS !== HTRANS_NONSEQ || bus.HWRITE !== 1'b1 || bus.HADDR !== 32'h200) begin
      bad++;
      $display("[TB] FAIL store_addr got htrans=%b hwrite=%b haddr=%h exp 10/1/200",
               bus.HTRANS, bus.HWRITE, bus.HADDR);
    end
    for (int c = 2; c <= 4; c++) begin
      next_cycle;
      bus.HREADY = (c == 4);
      @(negedge clk);
      total++;
      if (bus.HWDATA !== 32'h12345678 || bus.d_done !== (c == 4)) begin
        bad++;
        $display("[TB] FAIL store_data c%0d got hwdata=%h d_done=%b exp 12345678/%b",
                 c, bus.HWDATA, bus.d_done, (c == 4));
      end
    end
  endtask

  task automatic test_fetch_error;
    next_cycle;
    bus.f_req = 1'b1; bus.f_addr = 32'h80;
    push_exp(PORT_F, 1'b0, 1'b1, 32'hCAFEF00D);
    @(negedge clk);
    total++;
    if (bus.f_gnt !== 1'b1 || bus.d_gnt !== 1'b0) begin
      bad++;
      $display("[TB] FAIL fetch_gnt got f_gnt=%b d_gnt=%b exp 1/0", bus.f_gnt, bus.d_gnt);
    end
    next_cycle;
    bus.f_req = 1'b0;
    next_cycle;
    bus.HRDATA = 32'hCAFEF00D;
    @(negedge clk);
    total++;
    if (bus.f_done !== 1'b1 || bus.f_err !== 1'b0) begin
      bad++;
      $display("[TB] FAIL fetch_done got f_done=%b f_err=%b exp 1/0", bus.f_done, bus.f_err);
    end
    next_cycle;
    bus.f_req = 1'b1; bus.f_addr = 32'h43;
    push_exp(PORT_F, 1'b1, 1'b1, 32'h0);
    next_cycle;
    bus.f_req = 1'b0;
    @(negedge clk);
    total++;
    if (bus.HADDR !== 32'h40 || bus.HSIZE !== HSIZE_WORD || bus.HWRITE !== 1'b0 ||
        bus.HTRANS !== HTRANS_NONSEQ) begin
      bad++;
      $display("[TB] FAIL ferr_addr got haddr=%h hsize=%b hwrite=%b htrans=%b exp 40/010/0/10",
               bus.HADDR, bus.HSIZE, bus.HWRITE, bus.HTRANS);
    end
    next_cycle;
    bus.HREADY = 1'b0; bus.HRESP = 1'b1; bus.HRDATA = 32'hBAD0BAD0;
    @(negedge clk);
    total++;
    if (bus.f_done !== 1'b0) begin
      bad++;
      $display("[TB] FAIL ferr_first got f_done=%b exp 0", bus.f_done);
    end
    next_cycle;
    bus.HREADY = 1'b1;
    @(negedge clk);
    total++;
    if (bus.f_done !== 1'b1 || bus.f_err !== 1'b1) begin
      bad++;
      $display("[TB] FAIL ferr_second got f_done=%b f_err=%b exp 1/1", bus.f_done, bus.f_err);
    end
    next_cycle;
    bus.HRESP = 1'b0; bus.HRDATA = 32'h0;
    @(negedge clk);
    total++;
    if (bus.f_rdata !== 32'hCAFEF00D) begin
      bad++;
      $display("[TB] FAIL ferr_rdata got %h exp cafef00d", bus.f_rdata);
    end
  endtask

  task automatic test_starvation;
    logic      got;
    ahb_port_e exp_port;
    next_cycle;
    bus.d_req = 1'b1; bus.d_write = 1'b0; bus.d_addr = 32'h300; bus.d_size = HSIZE_WORD;
    bus.f_req = 1'b1; bus.f_addr = 32'h500;
    for (int i = 0; i < 6; i++) begin
      got = 1'b0;
      for (int w = 0; w < 8 && !got; w++) begin
        @(negedge clk);
        if (bus.d_gnt || bus.f_gnt) got = 1'b1;
      end
      exp_port = (i % 3 == 2) ? PORT_F : PORT_D;
      total++;
      if (!got) begin
        bad++;
        $display("[TB] FAIL starve_timeout grant %0d got none exp port=%0d", i, exp_port);
      end else if (bus.f_gnt !== (exp_port == PORT_F) || bus.d_gnt !== (exp_port == PORT_D)) begin
        bad++;
        $display("[TB] FAIL starve_order grant %0d got d_gnt=%b f_gnt=%b exp port=%0d",
                 i, bus.d_gnt, bus.f_gnt, exp_port);
      end
      if (got) begin
        bus.HRDATA = 32'hA000_0000 + 32'(i);
        push_exp(exp_port, 1'b0, 1'b1, 32'hA000_0000 + 32'(i));
      end
    end
    next_cycle;
    bus.d_req = 1'b0; bus.f_req = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_misaligned;
    logic [2:0]  sz [3];
    logic [31:0] ad [3];
    sz[0] = HSIZE_WORD; ad[0] = 32'h102;
    sz[1] = HSIZE_HALF; ad[1] = 32'h101;
    sz[2] = 3'b011;     ad[2] = 32'h100;
    for (int k = 0; k < 3; k++) begin
      next_cycle;
      bus.d_req = 1'b1; bus.d_write = 1'b0; bus.d_addr = ad[k]; bus.d_size = sz[k];
      push_exp(PORT_D, 1'b1, 1'b1, 32'h0);
      @(negedge clk);
      total++;
      if (bus.d_gnt !== 1'b1 || bus.HTRANS !== HTRANS_IDLE) begin
        bad++;
        $display("[TB] FAIL mis_gnt case %0d got d_gnt=%b htrans=%b exp 1/00", k, bus.d_gnt, bus.HTRANS);
      end
      next_cycle;
      bus.d_req = 1'b0;
      @(negedge clk);
      total++;
      if (bus.d_done !== 1'b1 || bus.d_err !== 1'b1 || bus.HTRANS !== HTRANS_IDLE) begin
        bad++;
        $display("[TB] FAIL mis_done case %0d got d_done=%b d_err=%b htrans=%b exp 1/1/00",
                 k, bus.d_done, bus.d_err, bus.HTRANS);
      end
      next_cycle;
      @(negedge clk);
      total++;
      if (bus.d_done !== 1'b0 || bus.HTRANS !== HTRANS_IDLE) begin
        bad++;
        $display("[TB] FAIL mis_after case %0d got d_done=%b htrans=%b exp 0/00", k, bus.d_done, bus.HTRANS);
      end
    end
  endtask

  task automatic test_reset_mid_data;
    next_cycle;
    bus.d_req = 1'b1; bus.d_write = 1'b0; bus.d_addr = 32'h400; bus.d_size = HSIZE_WORD;
    next_cycle;
    bus.d_req = 1'b0;
    next_cycle;
    bus.HREADY = 1'b0;
    #2;
    rst = 1'b1;
    model_d_rdata = 32'h0;
    model_f_rdata = 32'h0;
    #1;
    total++;
    if (bus.HTRANS !== HTRANS_IDLE || bus.HADDR !== 32'h0 || bus.HSIZE !== HSIZE_WORD ||
        bus.HWRITE !== 1'b0 || bus.HWDATA !== 32'h0) begin
      bad++;
      $display("[TB] FAIL rst_mid_bus got htrans=%b haddr=%h hsize=%b hwrite=%b hwdata=%h exp reset values",
               bus.HTRANS, bus.HADDR, bus.HSIZE, bus.HWRITE, bus.HWDATA);
    end
    total++;
    if (bus.d_done !== 1'b0 || bus.d_rdata !== 32'h0 || bus.f_rdata !== 32'h0) begin
      bad++;
      $display("[TB] FAIL rst_mid_port got d_done=%b d_rdata=%h f_rdata=%h exp 0/0/0",
               bus.d_done, bus.d_rdata, bus.f_rdata);
    end
    next_cycle;
    rst = 1'b0;
    bus.HREADY = 1'b1;
    next_cycle;
    bus.d_req = 1'b1; bus.d_addr = 32'h104;
    push_exp(PORT_D, 1'b0, 1'b1, 32'h77);
    @(negedge clk);
    total++;
    if (bus.d_gnt !== 1'b1) begin
      bad++;
      $display("[TB] FAIL rst_after_gnt got %b exp 1", bus.d_gnt);
    end
    next_cycle;
    bus.d_req = 1'b0;
    @(negedge clk);
    total++;
    if (bus.HADDR !== 32'h104 || bus.HTRANS !== HTRANS_NONSEQ) begin
      bad++;
      $display("[TB] FAIL rst_after_addr got haddr=%h htrans=%b exp 104/10", bus.HADDR, bus.HTRANS);
    end
    next_cycle;
    bus.HRDATA = 32'h77;
    @(negedge clk);
    total++;
    if (bus.d_done !== 1'b1) begin
      bad++;
      $display("[TB] FAIL rst_after_done got %b exp 1", bus.d_done);
    end
    next_cycle;
    bus.HRDATA = 32'h0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got no finish exp finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.d_req = 1'b0; bus.d_write = 1'b0; bus.d_addr = 32'h0; bus.d_size = HSIZE_WORD;
    bus.d_wdata = 32'h0; bus.f_req = 1'b0; bus.f_addr = 32'h0;
    bus.HRDATA = 32'h0; bus.HREADY = 1'b1; bus.HRESP = 1'b0;
    test_reset();
    test_zero_wait_load();
    test_store_wait();
    test_fetch_error();
    test_starvation();
    test_misaligned();
    test_reset_mid_data();
    repeat (2) @(negedge clk);
    total++;
    if (sb_q.size() !== 0) begin
      bad++;
      $display("[TB] FAIL sb_leftover got %0d pending exp 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
